// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: val/rdy pipeline register with a one-entry skid slot.
//
// Cuts every combinational path between producer and consumer (data, valid and
// ready) while still sustaining one transfer per cycle. The head word lives in
// the main register and drives deq_msg directly. When the consumer stalls, the
// one word already in flight from the producer is caught by the skid register,
// and enq_rdy drops on the following cycle.
//
// Parameters:
//   p_nbits        data width in bits
//   p_reset_value  value loaded into main and skid on reset
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   enq_val      upstream word valid
//   enq_rdy      block can accept a word this cycle
//   enq_msg      upstream data
//   deq_val      deq_msg holds a valid word
//   deq_rdy      downstream accepts the word this cycle
//   deq_msg      head data (always the main register)
//   num_entries  occupancy: 0, 1 or 2

module skid_pipe_reg #(
  parameter int unsigned          p_nbits       = 1,
  parameter logic [p_nbits-1:0]   p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [1:0]         num_entries
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e             state_q;
  logic [p_nbits-1:0] main_q;
  logic [p_nbits-1:0] skid_q;

  logic enq_fire;
  logic deq_fire;

  // Outputs depend only on the state register; enq_rdy is also masked by reset
  // so no handshake can complete while the block is being cleared.
  always_comb begin
    enq_rdy     = (state_q != StFull) && !reset;
    deq_val     = (state_q != StEmpty);
    deq_msg     = main_q;
    num_entries = 2'd0;
    case (state_q)
      StOne:   num_entries = 2'd1;
      StFull:  num_entries = 2'd2;
      default: num_entries = 2'd0;
    endcase
  end

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= p_reset_value;
      skid_q  <= p_reset_value;
    end else begin
      case (state_q)
        StEmpty: begin
          // deq cannot fire here since deq_val is low
          if (enq_fire) begin
            main_q  <= enq_msg;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (enq_fire && deq_fire) begin
            // pass-through: head leaves, new word becomes head
            main_q <= enq_msg;
          end else if (enq_fire) begin
            // consumer stalled: park the in-flight word behind the head
            skid_q  <= enq_msg;
            state_q <= StFull;
          end else if (deq_fire) begin
            // main keeps its stale contents; deq_val hides it
            state_q <= StEmpty;
          end
        end
        StFull: begin
          // enq cannot fire here since enq_rdy is low
          if (deq_fire) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

  // Simulation-time sanity checks on the control inputs and the occupancy.
  a_inputs_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({enq_val, deq_rdy}))
    else $error("skid_pipe_reg: enq_val or deq_rdy is X/Z");

  a_occupancy_legal: assert property (@(posedge clk) disable iff (reset)
    num_entries != 2'd3)
    else $error("skid_pipe_reg: illegal occupancy 3");

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Directed and random checks for skid_pipe_reg. An 8-bit instance (reset value
// 8'hA5) serves the directed scenarios; a 16-bit instance runs a random stress
// against a queue model. Inputs change 1 time unit after the rising edge and
// outputs are sampled there, well away from the next edge.

module tb_skid_pipe_reg;

  logic clk;
  logic reset;

  // 8-bit instance
  logic       enq_val8;
  logic       enq_rdy8;
  logic [7:0] enq_msg8;
  logic       deq_val8;
  logic       deq_rdy8;
  logic [7:0] deq_msg8;
  logic [1:0] num8;

  // 16-bit instance
  logic        enq_val16;
  logic        enq_rdy16;
  logic [15:0] enq_msg16;
  logic        deq_val16;
  logic        deq_rdy16;
  logic [15:0] deq_msg16;
  logic [1:0]  num16;

  int tests;
  int fails;

  skid_pipe_reg #(
    .p_nbits       (8),
    .p_reset_value (8'hA5)
  ) dut8 (
    .clk         (clk),
    .reset       (reset),
    .enq_val     (enq_val8),
    .enq_rdy     (enq_rdy8),
    .enq_msg     (enq_msg8),
    .deq_val     (deq_val8),
    .deq_rdy     (deq_rdy8),
    .deq_msg     (deq_msg8),
    .num_entries (num8)
  );

  skid_pipe_reg #(
    .p_nbits       (16),
    .p_reset_value (16'hBEEF)
  ) dut16 (
    .clk         (clk),
    .reset       (reset),
    .enq_val     (enq_val16),
    .enq_rdy     (enq_rdy16),
    .enq_msg     (enq_msg16),
    .deq_val     (deq_val16),
    .deq_rdy     (deq_rdy16),
    .deq_msg     (deq_msg16),
    .num_entries (num16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed 8-bit status: {deq_val, enq_rdy, num_entries, deq_msg}
  function automatic logic [11:0] obs8();
    return {deq_val8, enq_rdy8, num8, deq_msg8};
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    reset = 1'b1;
    enq_val8 = 1'b1;  // must be ignored while in reset
    enq_msg8 = 8'hFF;
    deq_rdy8 = 1'b1;
    step();
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b0, 2'd0, 8'hA5}) begin
      fails++;
      $display("FAIL reset_state got=%h required=%h", got, {1'b0, 1'b0, 2'd0, 8'hA5});
    end
    tests++;
    if ({deq_val16, enq_rdy16, num16, deq_msg16} !== {1'b0, 1'b0, 2'd0, 16'hBEEF}) begin
      fails++;
      $display("FAIL reset_state16 got=%h required=%h",
               {deq_val16, enq_rdy16, num16, deq_msg16}, {1'b0, 1'b0, 2'd0, 16'hBEEF});
    end
    enq_val8 = 1'b0;
    deq_rdy8 = 1'b0;
    reset = 1'b0;
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b1, 2'd0, 8'hA5}) begin
      fails++;
      $display("FAIL reset_release got=%h required=%h", got, {1'b0, 1'b1, 2'd0, 8'hA5});
    end
  endtask

  task automatic test_stream();
    logic [11:0] got;
    logic [11:0] req;
    deq_rdy8 = 1'b1;
    enq_val8 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      enq_msg8 = 8'(i);
      step();
      got = obs8();
      req = {1'b1, 1'b1, 2'd1, 8'(i)};
      tests++;
      if (got !== req) begin
        fails++;
        $display("FAIL stream_word%0d got=%h required=%h", i, got, req);
      end
    end
    enq_val8 = 1'b0;
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b1, 2'd0, 8'h04}) begin
      fails++;
      $display("FAIL stream_drain got=%h required=%h", got, {1'b0, 1'b1, 2'd0, 8'h04});
    end
  endtask

  task automatic test_skid();
    logic [11:0] got;
    deq_rdy8 = 1'b1;
    enq_val8 = 1'b1;
    enq_msg8 = 8'h10;
    step();                    // 10 becomes head
    enq_msg8 = 8'h11;
    deq_rdy8 = 1'b0;           // stall while 10 is first valid
    step();                    // 11 lands in skid
    got = obs8();
    tests++;
    if (got !== {1'b1, 1'b0, 2'd2, 8'h10}) begin
      fails++;
      $display("FAIL skid_capture got=%h required=%h", got, {1'b1, 1'b0, 2'd2, 8'h10});
    end
    enq_msg8 = 8'h12;          // held off: enq_rdy is low
    step();
    got = obs8();
    tests++;
    if (got !== {1'b1, 1'b0, 2'd2, 8'h10}) begin
      fails++;
      $display("FAIL skid_hold got=%h required=%h", got, {1'b1, 1'b0, 2'd2, 8'h10});
    end
    deq_rdy8 = 1'b1;
    step();                    // 10 leaves, 11 moves to head
    got = obs8();
    tests++;
    if (got !== {1'b1, 1'b1, 2'd1, 8'h11}) begin
      fails++;
      $display("FAIL skid_release got=%h required=%h", got, {1'b1, 1'b1, 2'd1, 8'h11});
    end
    step();                    // 11 leaves, 12 accepted as head
    got = obs8();
    tests++;
    if (got !== {1'b1, 1'b1, 2'd1, 8'h12}) begin
      fails++;
      $display("FAIL skid_third got=%h required=%h", got, {1'b1, 1'b1, 2'd1, 8'h12});
    end
    enq_val8 = 1'b0;
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b1, 2'd0, 8'h12}) begin
      fails++;
      $display("FAIL skid_empty got=%h required=%h", got, {1'b0, 1'b1, 2'd0, 8'h12});
    end
  endtask

  task automatic test_drain();
    logic [11:0] got;
    deq_rdy8 = 1'b0;
    enq_val8 = 1'b1;
    enq_msg8 = 8'h3C;
    step();
    got = obs8();
    tests++;
    if (got !== {1'b1, 1'b1, 2'd1, 8'h3C}) begin
      fails++;
      $display("FAIL drain_load got=%h required=%h", got, {1'b1, 1'b1, 2'd1, 8'h3C});
    end
    enq_val8 = 1'b0;
    enq_msg8 = 8'hEE;          // ignored, no enq
    deq_rdy8 = 1'b1;
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b1, 2'd0, 8'h3C}) begin
      fails++;
      $display("FAIL drain_empty got=%h required=%h", got, {1'b0, 1'b1, 2'd0, 8'h3C});
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] got;
    deq_rdy8 = 1'b0;
    enq_val8 = 1'b1;
    enq_msg8 = 8'h55;
    step();
    enq_msg8 = 8'h66;
    step();
    got = obs8();
    tests++;
    if (got !== {1'b1, 1'b0, 2'd2, 8'h55}) begin
      fails++;
      $display("FAIL midrst_full got=%h required=%h", got, {1'b1, 1'b0, 2'd2, 8'h55});
    end
    enq_val8 = 1'b0;
    reset = 1'b1;
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b0, 2'd0, 8'hA5}) begin
      fails++;
      $display("FAIL midrst_clear got=%h required=%h", got, {1'b0, 1'b0, 2'd0, 8'hA5});
    end
    reset = 1'b0;
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b1, 2'd0, 8'hA5}) begin
      fails++;
      $display("FAIL midrst_release got=%h required=%h", got, {1'b0, 1'b1, 2'd0, 8'hA5});
    end
    enq_val8 = 1'b1;
    enq_msg8 = 8'h77;
    deq_rdy8 = 1'b1;
    step();
    enq_val8 = 1'b0;
    got = obs8();
    tests++;
    if (got !== {1'b1, 1'b1, 2'd1, 8'h77}) begin
      fails++;
      $display("FAIL midrst_new got=%h required=%h", got, {1'b1, 1'b1, 2'd1, 8'h77});
    end
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b1, 2'd0, 8'h77}) begin
      fails++;
      $display("FAIL midrst_noghost got=%h required=%h", got, {1'b0, 1'b1, 2'd0, 8'h77});
    end
  endtask

  // Wiggle inputs mid-cycle in ONE and FULL; outputs must not move.
  task automatic test_comb_paths();
    logic [11:0] got;
    logic [11:0] req;
    deq_rdy8 = 1'b0;
    enq_val8 = 1'b1;
    enq_msg8 = 8'h21;
    step();                    // ONE, head 21
    for (int s = 0; s < 2; s++) begin
      req = (s == 0) ? {1'b1, 1'b1, 2'd1, 8'h21} : {1'b1, 1'b0, 2'd2, 8'h21};
      for (int k = 0; k < 4; k++) begin
        enq_val8 = k[0];
        deq_rdy8 = k[1];
        enq_msg8 = 8'(8'hC0 + k);
        #1;
        got = obs8();
        tests++;
        if (got !== req) begin
          fails++;
          $display("FAIL comb_path s%0d k%0d got=%h required=%h", s, k, got, req);
        end
      end
      enq_val8 = 1'b1;
      deq_rdy8 = 1'b0;
      enq_msg8 = 8'h22;
      step();                  // second pass runs in FULL
    end
    enq_val8 = 1'b0;
    deq_rdy8 = 1'b1;
    step();
    step();
    got = obs8();
    tests++;
    if (got !== {1'b0, 1'b1, 2'd0, 8'h22}) begin
      fails++;
      $display("FAIL comb_drain got=%h required=%h", got, {1'b0, 1'b1, 2'd0, 8'h22});
    end
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [34:0] got;
    logic [34:0] req;
    logic        v;
    logic        r;
    logic [15:0] d;
    logic        efire;
    logic        dfire;
    for (int c = 0; c < 1000; c++) begin
      req = {q.size() != 0, q.size() < 2, 2'(q.size()),
             (q.size() != 0) ? q[0] : 16'h0, 15'h0};
      got = {deq_val16, enq_rdy16, num16, deq_val16 ? deq_msg16 : 16'h0, 15'h0};
      tests++;
      if (got !== req) begin
        fails++;
        $display("FAIL random_c%0d got=%h required=%h", c, got[34:15], req[34:15]);
      end
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = 16'($urandom);
      // Wiggle first, then settle on the real inputs before the edge.
      enq_val16 = ~v;
      deq_rdy16 = ~r;
      enq_msg16 = ~d;
      #2;
      got = {deq_val16, enq_rdy16, num16, deq_val16 ? deq_msg16 : 16'h0, 15'h0};
      tests++;
      if (got !== req) begin
        fails++;
        $display("FAIL random_comb_c%0d got=%h required=%h", c, got[34:15], req[34:15]);
      end
      enq_val16 = v;
      deq_rdy16 = r;
      enq_msg16 = d;
      efire = v && (q.size() < 2);
      dfire = r && (q.size() != 0);
      step();
      if (dfire) void'(q.pop_front());
      if (efire) q.push_back(d);
    end
    enq_val16 = 1'b0;
    deq_rdy16 = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    enq_val8 = 1'b0;
    enq_msg8 = 8'h00;
    deq_rdy8 = 1'b0;
    enq_val16 = 1'b0;
    enq_msg16 = 16'h0000;
    deq_rdy16 = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_drain();
    test_mid_reset();
    test_comb_paths();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
